// File: rtl/islip_class_arbiter.sv
// islip_class_arbiter
// Registered request-grant-accept arbiter for one crossbar output port.
// It picks one input port out of P strict-priority classes. Each class keeps
// its own round-robin pointer, and a pointer moves only when its offer is
// accepted. The grant is held while a transfer is in progress. A class that
// keeps losing accepts ages up to a limit and is then boosted above the
// others.
module islip_class_arbiter #(
    parameter int N            = 25,
    parameter int P            = 8,
    parameter int RR_EN        = 1,
    parameter int AGE_W        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [P*N-1:0]   i_port_req,
    input  logic             i_accept,
    input  logic             i_release,
    output logic             o_grant_valid,
    output logic [N-1:0]     o_port_grant,
    output logic [P-1:0]     o_grant_priority,
    output logic             o_busy
);

    localparam int PTR_W    = (N > 1) ? $clog2(N) : 1;
    localparam int CLS_W    = (P > 1) ? $clog2(P) : 1;
    localparam int AGE_FULL = (1 << AGE_W) - 1;
    // Ages stop at the boost limit, or at counter full scale if that is lower
    // or if boosting is disabled.
    localparam int AGE_CAP  = (STARVE_LIMIT == 0 || STARVE_LIMIT > AGE_FULL)
                              ? AGE_FULL : STARVE_LIMIT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFER  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q;
    logic               grant_valid_q;
    logic [N-1:0]       port_grant_q;
    logic [P-1:0]       prio_q;
    logic               busy_q;
    logic [CLS_W-1:0]   cls_q;
    logic [PTR_W-1:0]   port_idx_q;
    logic [PTR_W-1:0]   ptr_q [P];
    logic [PTR_W-1:0]   ptr_d [P];
    logic [AGE_W-1:0]   age_q [P];
    logic [AGE_W-1:0]   age_d [P];

    logic [P-1:0]       cls_req_s;
    logic [P-1:0]       cls_boost_s;
    logic               any_req_s;
    logic               boost_any_s;
    logic [CLS_W-1:0]   cls_sel_s;
    logic [N-1:0]       cls_vec_s;
    logic [PTR_W-1:0]   ptr_cur_s;
    logic [PTR_W-1:0]   port_sel_s;
    logic [PTR_W-1:0]   idx_s;
    int                 sum_s;
    logic [N-1:0]       port_onehot_s;
    logic [P-1:0]       prio_onehot_s;
    logic               accept_s;
    logic [PTR_W-1:0]   ptr_inc_s;

    // Per-class request summary and starvation boost flags.
    always_comb begin
        cls_req_s   = '0;
        cls_boost_s = '0;
        for (int c = 0; c < P; c++) begin
            cls_req_s[c]   = |i_port_req[c*N +: N];
            cls_boost_s[c] = (STARVE_LIMIT != 0) && cls_req_s[c]
                             && (int'(age_q[c]) == STARVE_LIMIT);
        end
        any_req_s   = |cls_req_s;
        boost_any_s = |cls_boost_s;
    end

    // Class choice: lowest-index boosted class, else lowest-index requester.
    always_comb begin
        cls_sel_s = '0;
        for (int c = P - 1; c >= 0; c--) begin
            if (boost_any_s ? cls_boost_s[c] : cls_req_s[c]) begin
                cls_sel_s = CLS_W'(c);
            end else begin
                cls_sel_s = cls_sel_s;
            end
        end
    end

    // Port choice: first requester at or above the class pointer, wrapping.
    always_comb begin
        cls_vec_s  = '0;
        port_sel_s = '0;
        sum_s      = 0;
        idx_s      = '0;
        for (int c = 0; c < P; c++) begin
            if (CLS_W'(c) == cls_sel_s) begin
                cls_vec_s = i_port_req[c*N +: N];
            end else begin
                cls_vec_s = cls_vec_s;
            end
        end
        ptr_cur_s = (RR_EN != 0) ? ptr_q[cls_sel_s] : '0;
        // Walk downward so the smallest distance from the pointer wins.
        for (int k = N - 1; k >= 0; k--) begin
            sum_s = int'(ptr_cur_s) + k;
            if (sum_s >= N) begin
                sum_s = sum_s - N;
            end else begin
                sum_s = sum_s;
            end
            idx_s = PTR_W'(sum_s);
            if (cls_vec_s[idx_s]) begin
                port_sel_s = idx_s;
            end else begin
                port_sel_s = port_sel_s;
            end
        end
        port_onehot_s = {{(N-1){1'b0}}, 1'b1} << port_sel_s;
        prio_onehot_s = {{(P-1){1'b0}}, 1'b1} << cls_sel_s;
    end

    // Next pointer and age values, which change only on an accept event.
    always_comb begin
        accept_s  = (state_q == ST_OFFER) && i_accept;
        ptr_inc_s = (port_idx_q == PTR_W'(N - 1)) ? '0 : port_idx_q + 1'b1;
        for (int k = 0; k < P; k++) begin
            ptr_d[k] = ptr_q[k];
            age_d[k] = age_q[k];
            if (accept_s) begin
                if (CLS_W'(k) == cls_q) begin
                    ptr_d[k] = (RR_EN != 0) ? ptr_inc_s : '0;
                    age_d[k] = '0;
                end else if (cls_req_s[k]) begin
                    age_d[k] = (int'(age_q[k]) >= AGE_CAP) ? age_q[k]
                                                            : age_q[k] + 1'b1;
                end else begin
                    age_d[k] = '0;
                end
            end else begin
                age_d[k] = age_q[k];
            end
        end
    end

    // Pointer and age registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < P; k++) begin
                ptr_q[k] <= '0;
                age_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < P; k++) begin
                ptr_q[k] <= ptr_d[k];
                age_q[k] <= age_d[k];
            end
        end
    end

    // Offer/lock state machine with registered grant outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
            port_grant_q  <= '0;
            prio_q        <= '0;
            busy_q        <= 1'b0;
            cls_q         <= '0;
            port_idx_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_q       <= ST_OFFER;
                        grant_valid_q <= 1'b1;
                        port_grant_q  <= port_onehot_s;
                        prio_q        <= prio_onehot_s;
                        cls_q         <= cls_sel_s;
                        port_idx_q    <= port_sel_s;
                    end else begin
                        grant_valid_q <= 1'b0;
                        port_grant_q  <= '0;
                        prio_q        <= '0;
                    end
                    busy_q <= 1'b0;
                end
                ST_OFFER: begin
                    if (i_accept && !i_release) begin
                        state_q <= ST_LOCKED;
                        busy_q  <= 1'b1;
                    end else begin
                        // Declined offer or single-cycle transfer.
                        state_q       <= ST_IDLE;
                        grant_valid_q <= 1'b0;
                        port_grant_q  <= '0;
                        prio_q        <= '0;
                        busy_q        <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (i_release) begin
                        state_q       <= ST_IDLE;
                        grant_valid_q <= 1'b0;
                        port_grant_q  <= '0;
                        prio_q        <= '0;
                        busy_q        <= 1'b0;
                    end else begin
                        state_q <= ST_LOCKED;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    grant_valid_q <= 1'b0;
                    port_grant_q  <= '0;
                    prio_q        <= '0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant_valid    = grant_valid_q;
    assign o_port_grant     = port_grant_q;
    assign o_grant_priority = prio_q;
    assign o_busy           = busy_q;

endmodule

// File: tb/tb_islip_class_arbiter.sv
// Directed bench for islip_class_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_islip_class_arbiter;

    localparam int N = 25;
    localparam int P = 8;

    logic           clk;
    logic           reset;
    logic [P*N-1:0] req_a, req_b;
    logic           acc_a, rel_a, acc_b, rel_b;
    logic           val_a, busy_a, val_b, busy_b;
    logic [N-1:0]   port_a, port_b;
    logic [P-1:0]   prio_a, prio_b;

    int checks = 0;
    int errors = 0;

    islip_class_arbiter #(.N(N), .P(P), .RR_EN(1), .AGE_W(4), .STARVE_LIMIT(8)) dut_a (
        .clk(clk), .reset(reset), .i_port_req(req_a), .i_accept(acc_a),
        .i_release(rel_a), .o_grant_valid(val_a), .o_port_grant(port_a),
        .o_grant_priority(prio_a), .o_busy(busy_a)
    );

    islip_class_arbiter #(.N(N), .P(P), .RR_EN(0), .AGE_W(4), .STARVE_LIMIT(8)) dut_b (
        .clk(clk), .reset(reset), .i_port_req(req_b), .i_accept(acc_b),
        .i_release(rel_b), .o_grant_valid(val_b), .o_port_grant(port_b),
        .o_grant_priority(prio_b), .o_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        req_a = '0; acc_a = 1'b0; rel_a = 1'b0;
        req_b = '0; acc_b = 1'b0; rel_b = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", val_a); end
        checks++; if (port_a !== 25'd0) begin errors++; $display("FAIL reset_port got %0h exp 0", port_a); end
        checks++; if (prio_a !== 8'd0) begin errors++; $display("FAIL reset_prio got %0h exp 0", prio_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_a); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Ports 3 and 7 of class 0; accept+release moves pointer to 4; then a declined offer.
    task automatic test_basic_and_decline();
        req_a = '0; req_a[3] = 1'b1; req_a[7] = 1'b1;
        @(negedge clk);
        checks++; if (val_a !== 1'b1 || port_a !== 25'd8 || prio_a !== 8'd1 || busy_a !== 1'b0)
            begin errors++; $display("FAIL basic_offer3 got v%0b p%0h c%0h b%0b exp v1 p8 c1 b0", val_a, port_a, prio_a, busy_a); end
        acc_a = 1'b1; rel_a = 1'b1;
        @(negedge clk);
        checks++; if (val_a !== 1'b0 || port_a !== 25'd0) begin errors++; $display("FAIL basic_gap got v%0b p%0h exp v0 p0", val_a, port_a); end
        acc_a = 1'b0; rel_a = 1'b0;
        @(negedge clk);
        checks++; if (val_a !== 1'b1 || port_a !== 25'h80 || prio_a !== 8'd1)
            begin errors++; $display("FAIL basic_offer7 got v%0b p%0h c%0h exp v1 p80 c1", val_a, port_a, prio_a); end
        // Decline: outputs clear next cycle, pointer unchanged so port 7 again.
        @(negedge clk);
        checks++; if (val_a !== 1'b0 || port_a !== 25'd0 || prio_a !== 8'd0)
            begin errors++; $display("FAIL decline_clear got v%0b p%0h c%0h exp 0 0 0", val_a, port_a, prio_a); end
        @(negedge clk);
        checks++; if (val_a !== 1'b1 || port_a !== 25'h80) begin errors++; $display("FAIL decline_reoffer got v%0b p%0h exp v1 p80", val_a, port_a); end
        acc_a = 1'b1; rel_a = 1'b1;
        @(negedge clk);
        acc_a = 1'b0; rel_a = 1'b0; req_a = '0;
        @(negedge clk);
    endtask

    // Port 24 accepted wraps the pointer to 0; then {0,24} must pick 0.
    task automatic test_wrap();
        req_a = '0; req_a[24] = 1'b1;
        @(negedge clk);
        checks++; if (val_a !== 1'b1 || port_a !== 25'h1000000) begin errors++; $display("FAIL wrap_offer24 got v%0b p%0h exp v1 p1000000", val_a, port_a); end
        acc_a = 1'b1; rel_a = 1'b1;
        @(negedge clk);
        acc_a = 1'b0; rel_a = 1'b0; req_a[0] = 1'b1;
        @(negedge clk);
        checks++; if (val_a !== 1'b1 || port_a !== 25'd1) begin errors++; $display("FAIL wrap_port0 got v%0b p%0h exp v1 p1", val_a, port_a); end
        req_a = '0;
        @(negedge clk);
    endtask

    // Locked grant is held for 5 cycles while requests change; release gives one idle cycle.
    task automatic test_locked();
        req_a = '0; req_a[5] = 1'b1;
        @(negedge clk);
        checks++; if (val_a !== 1'b1 || port_a !== 25'h20) begin errors++; $display("FAIL lock_offer got v%0b p%0h exp v1 p20", val_a, port_a); end
        acc_a = 1'b1;
        @(negedge clk);
        acc_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_a = '0; req_a[i] = 1'b1; req_a[N + 2] = 1'b1;
            checks++; if (val_a !== 1'b1 || port_a !== 25'h20 || prio_a !== 8'd1 || busy_a !== 1'b1)
                begin errors++; $display("FAIL lock_hold%0d got v%0b p%0h c%0h b%0b exp v1 p20 c1 b1", i, val_a, port_a, prio_a, busy_a); end
            @(negedge clk);
        end
        // Requests now: class0 port 4, class1 port 2; pointer 0 is at 6.
        rel_a = 1'b1;
        @(negedge clk);
        rel_a = 1'b0;
        checks++; if (val_a !== 1'b0 || busy_a !== 1'b0 || port_a !== 25'd0)
            begin errors++; $display("FAIL lock_release got v%0b b%0b p%0h exp 0 0 0", val_a, busy_a, port_a); end
        @(negedge clk);
        checks++; if (val_a !== 1'b1 || port_a !== 25'h10 || prio_a !== 8'd1)
            begin errors++; $display("FAIL lock_next got v%0b p%0h c%0h exp v1 p10 c1", val_a, port_a, prio_a); end
        req_a = '0;
        @(negedge clk);
    endtask

    // Class 0 and class 7 always request; class 7 wins every 9th grant.
    task automatic test_starvation();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_a = '0; req_a[0] = 1'b1; req_a[7*N] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            checks++;
            if (val_a !== 1'b1 || port_a !== 25'd1 || prio_a !== ((i == 8 || i == 17) ? 8'h80 : 8'h01))
                begin errors++; $display("FAIL starve_grant%0d got v%0b p%0h c%0h exp c%0h", i, val_a, port_a, prio_a, (i == 8 || i == 17) ? 8'h80 : 8'h01); end
            acc_a = 1'b1; rel_a = 1'b1;
            @(negedge clk);
            acc_a = 1'b0; rel_a = 1'b0;
        end
        req_a = '0;
        @(negedge clk);
    endtask

    // Fixed priority: ports {2,5} always give port 2, grants every 2 cycles.
    task automatic test_back_to_back();
        req_b = '0; req_b[2] = 1'b1; req_b[5] = 1'b1;
        acc_b = 1'b1; rel_b = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (val_b !== 1'b1 || port_b !== 25'd4 || prio_b !== 8'd1)
                begin errors++; $display("FAIL b2b_grant%0d got v%0b p%0h c%0h exp v1 p4 c1", i, val_b, port_b, prio_b); end
            @(negedge clk);
            checks++; if (val_b !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d got v%0b exp 0", i, val_b); end
            @(negedge clk);
        end
        req_b = '0; acc_b = 1'b0; rel_b = 1'b0;
        @(negedge clk);
    endtask

    // Reset while locked clears outputs without a clock edge.
    task automatic test_async_reset();
        req_a = '0; req_a[2*N + 10] = 1'b1;
        @(negedge clk);
        acc_a = 1'b1;
        @(negedge clk);
        acc_a = 1'b0;
        checks++; if (busy_a !== 1'b1 || port_a !== 25'h400 || prio_a !== 8'h04)
            begin errors++; $display("FAIL areset_locked got b%0b p%0h c%0h exp b1 p400 c4", busy_a, port_a, prio_a); end
        #2 reset = 1'b0;
        #1;
        checks++; if (val_a !== 1'b0 || port_a !== 25'd0 || prio_a !== 8'd0 || busy_a !== 1'b0)
            begin errors++; $display("FAIL areset_clear got v%0b p%0h c%0h b%0b exp 0 0 0 0", val_a, port_a, prio_a, busy_a); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (val_a !== 1'b1 || port_a !== 25'h400 || prio_a !== 8'h04 || busy_a !== 1'b0)
            begin errors++; $display("FAIL areset_regrant got v%0b p%0h c%0h b%0b exp v1 p400 c4 b0", val_a, port_a, prio_a, busy_a); end
        req_a = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_and_decline();
        test_wrap();
        test_locked();
        test_starvation();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/islip_class_arbiter.md
# islip_class_arbiter

Registered, multi-class request-grant-accept arbiter for one output port of the iSLIP crossbar scheduler. It selects one of N input ports from P strict-priority classes, with per-class round-robin pointers updated only on accept (iSLIP rule). It holds the grant across multi-cycle transfers and boosts starved classes. It is the next generation of the combinational grant selector: it adds an offer/accept handshake, grant locking, and starvation protection.

## Interface
- N, 25, input ports per class
- P, 8, priority classes; class 0 is highest
- RR_EN, 1, 1 = per-class round-robin pointers; 0 = fixed lowest-index-first
- AGE_W, 4, width of per-class starvation counters
- STARVE_LIMIT, 8, age at which a class is boosted; 0 disables boosting
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_port_req  input  P*N  bit c*N+j = port j requests in class c
- i_accept  input  1  downstream accepts the current offer; sampled only in OFFER
- i_release  input  1  end of transfer; sampled in LOCKED, or in OFFER together with i_accept
- o_grant_valid  output  1  offer or locked grant present
- o_port_grant  output  N  one-hot granted port; zero when o_grant_valid=0
- o_grant_priority  output  P  one-hot granted class; zero when o_grant_valid=0
- o_busy  output  1  high in LOCKED

## Operation
- States: IDLE, OFFER, LOCKED. All outputs are registered.
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; all pointers 0; all ages 0.
- Class selection in IDLE:
  - If any class with requests has age==STARVE_LIMIT (and STARVE_LIMIT≠0), pick the lowest-index such class.
  - Otherwise pick the lowest-index class with any request.
- Port selection within the chosen class c: the first requesting port at index ≥ ptr[c], searching upward and wrapping N-1→0. With RR_EN=0, ptr stays 0.
- IDLE: if any request exists, register the grant and go to OFFER. Otherwise stay in IDLE with outputs 0.
- OFFER:
  - i_accept=1, i_release=0: ptr[c] ← (granted port + 1) mod N; go LOCKED.
  - i_accept=1, i_release=1: ptr[c] updated as above; go IDLE (single-cycle transfer).
  - i_accept=0: go IDLE. Pointer is unchanged and the outputs clear. The next cycle re-arbitrates against current requests.
- LOCKED: grant outputs held; i_port_req ignored for selection; on i_release go IDLE and clear outputs.
- Ages update only on an accept event, for every class k:
  - k accepted: age ← 0.
  - k not accepted and has requests at the accept cycle: age ← age+1, saturating at STARVE_LIMIT (and at 2^AGE_W−1).
  - k has no requests: age ← 0.
- The pointer width is clog2(N). The wrap from N-1 goes to 0, including for non-power-of-2 N.

## Timing
- Request sampled in IDLE at edge t → o_grant_valid=1 after edge t (cycle t+1).
- Offer lasts exactly one cycle unless accepted.
- Accept at the edge ending cycle t+1 → LOCKED from cycle t+2; o_port_grant and o_grant_priority are unchanged.
- After release, outputs are 0 for one cycle (IDLE). Minimum spacing between grants is 2 cycles.
- A boosted class takes effect at the next IDLE selection after its age reaches the limit.
- Asserting reset mid-LOCKED clears all outputs immediately, without waiting for a clock edge. After deassertion the next grant follows the normal one-cycle latency.

## Test plan
- Reset, then req class0 ports {3,7} → offer port3/class0 at latency 1. Accept and release → ptr0=4. Next offer is port7.
- Single requester at port N-1 (24) accepted → ptr wraps to 0. Next request at port 0 is granted first.
- Offer with i_accept=0 → outputs return to 0 the next cycle, ptr unchanged, same port re-offered.
- Accept without release for 5 cycles while class0 requests change → grant, priority and o_busy stay constant. Release → IDLE for one cycle.
- Class0 and class7 request continuously, STARVE_LIMIT=8, each offer accepted and released → class7 is granted after 8 class0 accepts, then its age returns to 0.
- RR_EN=0 with ports {2,5} → port2 always granted. Accept+release in the same cycle → back-to-back grants every 2 cycles.
